demux_dois_canais: RTL and testbench

DEMUX_DOIS_CANAIS -- requirements
Module: demux_dois_canais

---
 rtl/demux_pkg.sv | 22 ++
 rtl/demux_dois_canais_sincronizador.sv | 29 ++
 rtl/demux_dois_canais.sv | 200 ++++++++++++++++++++
 tb/tb_demux_dois_canais.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the two-channel demultiplexer slice.
//   - FSM state encoding (kept as plain 2-bit constants for legacy compatibility)
//   - default parameter values for demux_dois_canais
//   - helper to size the phase counter
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam logic [1:0] BUSCA   = 2'd0;
    localparam logic [1:0] SINC    = 2'd1;
    localparam logic [1:0] TRAVADO = 2'd2;

    localparam int unsigned FREQUENCIA_CLK_PADRAO = 25_000_000;
    localparam int unsigned ESTAVEL_CICLOS_PADRAO = 4;

    // Phase counter must hold values 0 .. 2*freq inclusive.
    function automatic int unsigned largura_fase(input int unsigned freq);
        return $clog2(2 * freq + 1);
    endfunction

endpackage

// File: rtl/demux_dois_canais_sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador_bit
// Two-flop synchronizer for a single bit crossing into the clk domain.
// Ports:
//   clk     in   destination clock
//   reset_n in   asynchronous active-low reset, both flops cleared to 0
//   entrada in   asynchronous input bit
//   saida   out  synchronized bit (two clk edges of latency)
// -----------------------------------------------------------------------------
module sincronizador_bit (
    input  logic clk,
    input  logic reset_n,
    input  logic entrada,
    output logic saida
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta  <= 1'b0;
            saida <= 1'b0;
        end else begin
            meta  <= entrada;
            saida <= meta;
        end
    end

endmodule

// File: rtl/demux_dois_canais.sv
// -----------------------------------------------------------------------------
// demux_dois_canais
// Splits a time-multiplexed 16-bit word into channel A (selector low) and
// channel B (selector high). Each selector phase is captured once, after the
// data has been stable for ESTAVEL_CICLOS cycles. A BUSCA/SINC/TRAVADO FSM
// checks that selector phases have a plausible length and raises a sticky
// watchdog error when the selector stops toggling.
// Optional feature: define DEMUX_CONTADOR_ERROS_EN to count lock losses on
// contador_erros; otherwise the port is tied to zero.
// Ports:
//   clk             in   system clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   entrada_mux     in   16-bit multiplexed data
//   entrada_seletor in   phase selector (may be asynchronous)
//   limpa_erro      in   synchronous clear of erro_timeout / contador_erros
//   canal_a/canal_b out  last captured word per channel
//   valido_a/_b     out  one-cycle capture strobe, only while locked
//   travado         out  FSM in TRAVADO
//   erro_timeout    out  sticky watchdog error
//   contador_erros  out  lock-loss count (saturating at 255)
// -----------------------------------------------------------------------------
module demux_dois_canais
    import demux_pkg::*;
#(
    parameter int unsigned FREQUENCIA_CLK = FREQUENCIA_CLK_PADRAO,
    parameter int unsigned ESTAVEL_CICLOS = ESTAVEL_CICLOS_PADRAO
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] entrada_mux,
    input  logic        entrada_seletor,
    input  logic        limpa_erro,
    output logic [15:0] canal_a,
    output logic [15:0] canal_b,
    output logic        valido_a,
    output logic        valido_b,
    output logic        travado,
    output logic        erro_timeout,
    output logic [7:0]  contador_erros
);

    localparam int unsigned LARG_FASE = largura_fase(FREQUENCIA_CLK);
    localparam int unsigned LARG_EST  = $clog2(ESTAVEL_CICLOS);

    localparam logic [LARG_FASE-1:0] FASE_MAX     = LARG_FASE'(2 * FREQUENCIA_CLK);
    localparam logic [LARG_FASE-1:0] FASE_TIMEOUT = LARG_FASE'(2 * FREQUENCIA_CLK - 1);
    localparam logic [LARG_FASE-1:0] FASE_MIN     = LARG_FASE'(FREQUENCIA_CLK / 2);
    localparam logic [LARG_EST-1:0]  EST_MAX      = LARG_EST'(ESTAVEL_CICLOS - 1);
    localparam logic [LARG_EST-1:0]  EST_PENULT   = LARG_EST'(ESTAVEL_CICLOS - 2);

    logic                 sel_sinc;
    logic                 sel_ant;
    logic [15:0]          dado_p1;
    logic [15:0]          dado_p2;
    logic [15:0]          dado_ant;
    logic [LARG_EST-1:0]  estavel;
    logic [LARG_FASE-1:0] fase;
    logic                 capturado;
    logic [1:0]           estado;
    logic [1:0]           estado_prox;
    logic                 borda;
    logic                 estavel_agora;
    logic                 timeout;
    logic                 captura;

    sincronizador_bit u_sinc_seletor (
        .clk     (clk),
        .reset_n (reset_n),
        .entrada (entrada_seletor),
        .saida   (sel_sinc)
    );

    // Two data stages keep the word aligned with the synchronized selector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dado_p1  <= '0;
            dado_p2  <= '0;
            dado_ant <= '0;
            sel_ant  <= 1'b0;
        end else begin
            dado_p1  <= entrada_mux;
            dado_p2  <= dado_p1;
            dado_ant <= dado_p2;
            sel_ant  <= sel_sinc;
        end
    end

    assign borda         = sel_sinc ^ sel_ant;
    assign estavel_agora = !borda && (dado_p2 == dado_ant);
    // A selector edge in the same cycle as the watchdog limit wins.
    assign timeout       = !borda && (fase == FASE_TIMEOUT);
    // Capture loads on the same edge the stability count reaches
    // ESTAVEL_CICLOS-1, giving ESTAVEL_CICLOS+2 edges of input-to-output latency.
    assign captura       = estavel_agora && (estavel == EST_PENULT) && !capturado
                           && (estado != BUSCA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estavel   <= '0;
            fase      <= '0;
            capturado <= 1'b0;
        end else begin
            if (!estavel_agora) begin
                estavel <= '0;
            end else if (estavel != EST_MAX) begin
                estavel <= estavel + LARG_EST'(1);
            end

            if (borda) begin
                fase <= '0;
            end else if (fase != FASE_MAX) begin
                fase <= fase + LARG_FASE'(1);
            end

            if (borda) begin
                capturado <= 1'b0;
            end else if (captura) begin
                capturado <= 1'b1;
            end
        end
    end

    always_comb begin
        estado_prox = estado;
        if (borda) begin
            case (estado)
                BUSCA:   estado_prox = SINC;
                SINC:    estado_prox = (fase < FASE_MIN) ? BUSCA : TRAVADO;
                TRAVADO: estado_prox = (fase < FASE_MIN) ? BUSCA : TRAVADO;
                default: estado_prox = BUSCA;
            endcase
        end else if (timeout) begin
            estado_prox = BUSCA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= BUSCA;
        end else begin
            estado <= estado_prox;
        end
    end

    assign travado = (estado == TRAVADO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            canal_a  <= '0;
            canal_b  <= '0;
            valido_a <= 1'b0;
            valido_b <= 1'b0;
        end else begin
            valido_a <= 1'b0;
            valido_b <= 1'b0;
            if (captura) begin
                if (sel_sinc) begin
                    canal_b  <= dado_p2;
                    valido_b <= (estado == TRAVADO);
                end else begin
                    canal_a  <= dado_p2;
                    valido_a <= (estado == TRAVADO);
                end
            end
        end
    end

    // Setting the error has priority over clearing it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            erro_timeout <= 1'b0;
        end else if (timeout) begin
            erro_timeout <= 1'b1;
        end else if (limpa_erro) begin
            erro_timeout <= 1'b0;
        end
    end

`ifdef DEMUX_CONTADOR_ERROS_EN
    logic perda_trava;

    assign perda_trava = (estado == TRAVADO) && (estado_prox == BUSCA);

    // An increment in the same cycle as limpa_erro takes precedence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            contador_erros <= '0;
        end else if (perda_trava) begin
            if (contador_erros != '1) begin
                contador_erros <= contador_erros + 8'd1;
            end
        end else if (limpa_erro) begin
            contador_erros <= '0;
        end
    end
`else
    assign contador_erros = '0;
`endif

endmodule

// File: tb/tb_demux_dois_canais.sv
// -----------------------------------------------------------------------------
// tb_demux_dois_canais
// Self-checking bench for demux_dois_canais with FREQUENCIA_CLK=20,
// ESTAVEL_CICLOS=4. The reference model works on the sequence of driven
// samples: selector-edge gaps, run lengths of unchanged input, and the
// phase-plausibility rules. Each predicted effect is queued with the clk edge
// at which it must become visible; an independent monitor applies matured
// events to shadow outputs and compares every cycle.
// Honors DEMUX_CONTADOR_ERROS_EN for the lock-loss counter expectations.
// -----------------------------------------------------------------------------
module tb_demux_dois_canais;

    localparam int F = 20;
    localparam int E = 4;
    // Every driven sample reaches the FSM / capture registers this many edges later.
    localparam int ATRASO = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] entrada_mux = '0;
    logic        entrada_seletor = 1'b0;
    logic        limpa_erro = 1'b0;
    logic [15:0] canal_a;
    logic [15:0] canal_b;
    logic        valido_a;
    logic        valido_b;
    logic        travado;
    logic        erro_timeout;
    logic [7:0]  contador_erros;

    always #5 clk = ~clk;

    demux_dois_canais #(
        .FREQUENCIA_CLK (F),
        .ESTAVEL_CICLOS (E)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .entrada_mux     (entrada_mux),
        .entrada_seletor (entrada_seletor),
        .limpa_erro      (limpa_erro),
        .canal_a         (canal_a),
        .canal_b         (canal_b),
        .valido_a        (valido_a),
        .valido_b        (valido_b),
        .travado         (travado),
        .erro_timeout    (erro_timeout),
        .contador_erros  (contador_erros)
    );

    typedef enum {EV_CAP_A, EV_CAP_B, EV_TRAVA, EV_ERRO, EV_LIMPA, EV_PERDA} ev_kind_t;
    typedef struct {
        int          cyc;
        ev_kind_t    kind;
        logic [15:0] dado;
        logic        flag;
    } ev_t;
    typedef enum {M_BUSCA, M_SINC, M_TRAV} modo_t;

    ev_t fila[$];
    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;

    // shadow of what the outputs must show
    logic [15:0] exp_a, exp_b;
    logic        exp_trav, exp_erro;
    int          exp_cont;

    // reference model state
    logic        m_sel;
    logic [15:0] m_dado;
    int          m_ult;     // sample index of last selector change
    int          m_ini;     // sample index where the current unchanged run began
    logic        m_capt;
    modo_t       m_modo;

    logic        sel_atual;
    logic [15:0] dado_atual;

    task automatic compara(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        compared++;
        if (atual !== esperado) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nome, cyc, atual, esperado);
        end
    endtask

    function automatic void empilha(input int c, input ev_kind_t k, input logic [15:0] d, input logic f);
        ev_t e;
        e.cyc = c; e.kind = k; e.dado = d; e.flag = f;
        fila.push_back(e);
    endfunction

    function automatic void muda_modo(input int n, input modo_t novo);
        if (m_modo == M_TRAV && novo == M_BUSCA) empilha(n + ATRASO, EV_PERDA, '0, 1'b0);
        if ((novo == M_TRAV) != (m_modo == M_TRAV)) empilha(n + ATRASO, EV_TRAVA, '0, novo == M_TRAV);
        m_modo = novo;
    endfunction

    function automatic void modelo(input int n, input logic s, input logic [15:0] d, input logic l);
        logic ms;
        int   fase_v;
        ms = (s != m_sel);
        if (l) empilha(n + 1, EV_LIMPA, '0, 1'b0);
        if (ms || d != m_dado) m_ini = n;
        if (!ms && (n - m_ini + 1 == E) && !m_capt && m_modo != M_BUSCA) begin
            empilha(n + ATRASO, s ? EV_CAP_B : EV_CAP_A, d, m_modo == M_TRAV);
            m_capt = 1'b1;
        end
        if (ms) begin
            fase_v = n - m_ult - 1;
            if (fase_v > 2 * F) fase_v = 2 * F;
            case (m_modo)
                M_BUSCA: muda_modo(n, M_SINC);
                default: muda_modo(n, (fase_v < F / 2) ? M_BUSCA : M_TRAV);
            endcase
            m_capt = 1'b0;
            m_ult  = n;
        end else if (n - m_ult == 2 * F) begin
            empilha(n + ATRASO, EV_ERRO, '0, 1'b1);
            muda_modo(n, M_BUSCA);
        end
        m_sel  = s;
        m_dado = d;
    endfunction

    // ---------------- monitor ----------------
    logic va, vb, ev_set, ev_clr, ev_inc;
    int   idx;

    always @(negedge clk) begin
        if (reset_n) begin
            va = 1'b0; vb = 1'b0; ev_set = 1'b0; ev_clr = 1'b0; ev_inc = 1'b0;
            idx = 0;
            while (idx < fila.size()) begin
                if (fila[idx].cyc <= cyc) begin
                    case (fila[idx].kind)
                        EV_CAP_A: begin exp_a = fila[idx].dado; if (fila[idx].flag) va = 1'b1; end
                        EV_CAP_B: begin exp_b = fila[idx].dado; if (fila[idx].flag) vb = 1'b1; end
                        EV_TRAVA: exp_trav = fila[idx].flag;
                        EV_ERRO:  ev_set = 1'b1;
                        EV_LIMPA: ev_clr = 1'b1;
                        EV_PERDA: ev_inc = 1'b1;
                        default:  ;
                    endcase
                    fila.delete(idx);
                end else begin
                    idx++;
                end
            end
            if (ev_set) exp_erro = 1'b1;
            else if (ev_clr) exp_erro = 1'b0;
`ifdef DEMUX_CONTADOR_ERROS_EN
            if (ev_inc) exp_cont = (exp_cont < 255) ? exp_cont + 1 : 255;
            else if (ev_clr) exp_cont = 0;
`endif
            compara("valido_a", valido_a, va);
            compara("valido_b", valido_b, vb);
            if (valido_a || va) compara("canal_a_strobe", canal_a, exp_a);
            if (valido_b || vb) compara("canal_b_strobe", canal_b, exp_b);
            compara("canal_a", canal_a, exp_a);
            compara("canal_b", canal_b, exp_b);
            compara("travado", travado, exp_trav);
            compara("erro_timeout", erro_timeout, exp_erro);
            compara("contador_erros", contador_erros, exp_cont);
        end
    end

    // ---------------- stimulus ----------------
    task automatic passo(input logic s, input logic [15:0] d, input logic l);
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        entrada_seletor = s;
        entrada_mux     = d;
        limpa_erro      = l;
        sel_atual       = s;
        dado_atual      = d;
        modelo(cyc, s, d, l);
    endtask

    task automatic segmento(input logic s, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) passo(s, d, 1'b0);
    endtask

    // Normal phases: toggle selector, channel word depends on phase, F cycles each.
    task automatic fases_normais(input int k);
        for (int i = 0; i < k; i++)
            segmento(~sel_atual, sel_atual ? 16'h1234 : 16'hABCD, F);
    endtask

    task automatic aplica_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        entrada_seletor = 1'b0;
        entrada_mux = '0;
        limpa_erro = 1'b0;
        #1;
        compara("rst_canal_a", canal_a, 16'h0);
        compara("rst_canal_b", canal_b, 16'h0);
        compara("rst_valido_a", valido_a, 1'b0);
        compara("rst_valido_b", valido_b, 1'b0);
        compara("rst_travado", travado, 1'b0);
        compara("rst_erro", erro_timeout, 1'b0);
        compara("rst_contador", contador_erros, 8'h0);
        fila.delete();
        exp_a = '0; exp_b = '0; exp_trav = 1'b0; exp_erro = 1'b0; exp_cont = 0;
        m_sel = 1'b0; m_dado = '0; m_ult = -ATRASO; m_ini = -ATRASO;
        m_capt = 1'b0; m_modo = M_BUSCA;
        sel_atual = 1'b0; dado_atual = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        modelo(0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        logic        sel_r;
        logic [15:0] dado_r;
        int          resta;

        aplica_reset();

        // lock on regular phases
        segmento(1'b0, 16'h1234, F);
        fases_normais(6);
        compara("lock_travado", travado, 1'b1);
        compara("lock_canal_a", canal_a, 16'h1234);
        compara("lock_canal_b", canal_b, 16'hABCD);

        // three-cycle selector glitch while locked
        segmento(~sel_atual, sel_atual ? 16'h1234 : 16'hABCD, 12);
        segmento(~sel_atual, dado_atual, 3);
        segmento(~sel_atual, dado_atual, F);
        compara("glitch_travado", travado, 1'b0);
`ifdef DEMUX_CONTADOR_ERROS_EN
        compara("glitch_contador", contador_erros, 8'd1);
`else
        compara("glitch_contador", contador_erros, 8'd0);
`endif

        // data toggling every 2 cycles: no capture, channels hold
        fases_normais(3);
        compara("relock_travado", travado, 1'b1);
        sel_r = ~sel_atual;
        for (int i = 0; i < F; i++) passo(sel_r, ((i / 2) % 2 == 0) ? 16'h5555 : 16'hAAAA, 1'b0);
        compara("instavel_canal_a", canal_a, 16'h1234);
        compara("instavel_canal_b", canal_b, 16'hABCD);

        // selector frozen -> watchdog, then clear
        fases_normais(3);
        segmento(sel_atual, dado_atual, 50);
        compara("timeout_erro", erro_timeout, 1'b1);
        compara("timeout_travado", travado, 1'b0);
        passo(sel_atual, dado_atual, 1'b1);
        segmento(sel_atual, dado_atual, 2);
        compara("limpa_erro", erro_timeout, 1'b0);

        // edge exactly at the watchdog limit: edge wins, still locked
        fases_normais(2);
        segmento(~sel_atual, dado_atual, 2 * F);
        segmento(~sel_atual, dado_atual, 10);
        compara("borda_limite_erro", erro_timeout, 1'b0);
        compara("borda_limite_travado", travado, 1'b1);

        // limpa_erro coinciding with watchdog: error stays set
        segmento(~sel_atual, dado_atual, 2 * F + 2);
        passo(sel_atual, dado_atual, 1'b1);
        segmento(sel_atual, dado_atual, 3);
        compara("limpa_vs_timeout", erro_timeout, 1'b1);
        passo(sel_atual, dado_atual, 1'b1);
        segmento(sel_atual, dado_atual, 2);

        // randomized traffic
        sel_r = sel_atual;
        dado_r = dado_atual;
        resta = 0;
        for (int i = 0; i < 1500; i++) begin
            if (resta == 0) begin
                resta = ($urandom_range(0, 5) == 0) ? int'($urandom_range(36, 46)) : int'($urandom_range(1, 24));
                if ($urandom_range(0, 4) != 0) sel_r = ~sel_r;
                dado_r = ($urandom_range(0, 1) != 0) ? 16'h1234 : 16'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                dado_r = 16'($urandom);
            end
            passo(sel_r, dado_r, $urandom_range(0, 39) == 0);
            resta--;
        end

        // asynchronous reset mid-run, then relock
        fases_normais(4);
        aplica_reset();
        segmento(1'b0, 16'h0F0F, F);
        fases_normais(3);
        compara("pos_reset_travado", travado, 1'b1);

`ifdef DEMUX_CONTADOR_ERROS_EN
        aplica_reset();
        for (int i = 0; i < 260; i++) begin
            segmento(~sel_atual, 16'h0101, F);
            segmento(~sel_atual, 16'h0202, F);
            segmento(~sel_atual, 16'h0303, 3);
        end
        segmento(sel_atual, dado_atual, 5);
        compara("contador_saturado", contador_erros, 8'd255);
        passo(sel_atual, dado_atual, 1'b1);
        segmento(sel_atual, dado_atual, 2);
        compara("contador_limpo", contador_erros, 8'd0);
`endif

        segmento(sel_atual, dado_atual, 8);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
